// File: rtl/lsm_sequencer.sv
// rtl/lsm_sequencer.sv - load/store-multiple sequencer walking a register mask lowest index first.
// Optional LSM_WRITEBACK_EN adds a final base-register write-back of the end address.
module lsm_sequencer #(
  parameter int NREGS  = 8,
  parameter int AW     = 16,
  parameter int STRIDE = 1,
  parameter int IW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             proc_rst,
  input  logic             start,
  input  logic             is_store,
  input  logic [AW-1:0]    base_addr,
  input  logic [NREGS-1:0] reg_mask,
  input  logic [IW-1:0]    base_reg,
  input  logic             abort,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [IW-1:0]    rf_raddr,
  output logic             rf_wen,
  output logic [IW-1:0]    rf_waddr,
  output logic [AW-1:0]    wb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ACCESS, S_LOADWR, S_WB, S_DONE
  } state_t;

  state_t           r_state;
  logic [NREGS-1:0] r_mask;
  logic [AW-1:0]    r_ptr;
  logic [IW-1:0]    r_idx;
  logic             r_is_store;
  logic             r_abort_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [IW-1:0]    r_rf_raddr;
  logic             r_rf_wen;
  logic [IW-1:0]    r_rf_waddr;
  logic [IW-1:0]    w_low;

  // Descending scan so the lowest set bit is the last assignment and wins.
  always_comb begin
    w_low = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (r_mask[i]) w_low = IW'(i);
    end
  end

`ifdef LSM_WRITEBACK_EN
  logic [AW-1:0] r_wb_data;
  assign wb_data = r_wb_data;
`else
  logic w_unused_base_reg;
  assign w_unused_base_reg = ^base_reg;
  assign wb_data = '0;
`endif

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_is_store   <= 1'b0;
      r_abort_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_rf_raddr   <= '0;
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= '0;
`ifdef LSM_WRITEBACK_EN
      r_wb_data    <= '0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_rf_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store   <= is_store;
            r_mask       <= reg_mask;
            r_ptr        <= base_addr;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_mask == '0) begin
`ifdef LSM_WRITEBACK_EN
            r_rf_wen   <= 1'b1;
            r_rf_waddr <= base_reg;
            r_wb_data  <= r_ptr;
            r_state    <= S_WB;
`else
            r_done  <= 1'b1;
            r_state <= S_DONE;
`endif
          end else begin
            r_idx      <= w_low;
            r_mem_req  <= 1'b1;
            r_mem_we   <= r_is_store;
            r_mem_addr <= r_ptr;
            r_rf_raddr <= w_low;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // An abort here is only remembered; the memory handshake must finish first.
          if (abort) r_abort_pend <= 1'b1;
          if (mem_ready) begin
            r_mask    <= r_mask & ~(NREGS'(1) << r_idx);
            r_ptr     <= r_ptr + AW'(STRIDE);
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (abort || r_abort_pend) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_is_store) begin
              r_state <= S_SCAN;
            end else begin
              r_rf_wen   <= 1'b1;
              r_rf_waddr <= r_idx;
              r_state    <= S_LOADWR;
            end
          end
        end
        S_LOADWR: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_WB: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign rf_raddr = r_rf_raddr;
  assign rf_wen   = r_rf_wen;
  assign rf_waddr = r_rf_waddr;

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb/tb_lsm_sequencer.sv - directed and randomized checks of lsm_sequencer against a sequence-level model.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [2:0]  base_reg;
  logic        abort;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  rf_raddr;
  logic        rf_wen;
  logic [2:0]  rf_waddr;
  logic [15:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  lsm_sequencer dut (
    .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .base_reg(base_reg),
    .abort(abort), .mem_ready(mem_ready), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .rf_raddr(rf_raddr), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rf_wen"}, rf_wen, 0);
    check({tag, "_rf_raddr"}, rf_raddr, 0);
  endtask

  // Model: accesses are the set bits in ascending order at consecutive addresses;
  // done timing follows the per-access cycle cost of store vs load.
  task automatic run_seq(input bit st, input logic [15:0] base, input logic [7:0] mask,
                         input int w, input logic [2:0] breg);
    logic [15:0] exp_addr[$];
    int          exp_idx[$];
    int          exp_wr[$];
    int          got_wr[$];
    int          k, exp_done, a, wc, cyc, req_cycles;
    bit          seen_done;
    logic [15:0] exp_wb;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        exp_idx.push_back(i);
        exp_addr.push_back(base + 16'(k));
        k++;
      end
    end
    if (!st) exp_wr = exp_idx;
    exp_done = st ? 2 + k * (2 + w) : 2 + k * (3 + w);
`ifdef LSM_WRITEBACK_EN
    exp_wr.push_back(int'(breg));
    exp_done++;
    exp_wb = base + 16'(k);
`else
    exp_wb = 16'h0;
`endif
    @(negedge clk);
    start = 1'b1; is_store = st; base_addr = base; reg_mask = mask; base_reg = breg;
    @(negedge clk);
    start = 1'b0;
    is_store = 1'($urandom); base_addr = 16'($urandom); reg_mask = 8'($urandom);
    a = 0; wc = 0; req_cycles = 0; seen_done = 0; cyc = 1;
    while (!seen_done && cyc <= 200) begin
      if (cyc > 1) @(negedge clk);
      check("busy_during", busy, 1);
      if (mem_req) begin
        req_cycles++;
        if (a < k) begin
          check("mem_addr", mem_addr, exp_addr[a]);
          check("rf_raddr", rf_raddr, exp_idx[a]);
          check("mem_we", mem_we, st);
        end else begin
          check("extra_req", mem_req, 0);
        end
        if (wc == w) begin
          mem_ready = 1'b1; wc = 0; a++;
        end else begin
          mem_ready = 1'b0; wc++;
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (rf_wen) got_wr.push_back(int'(rf_waddr));
      if (done) begin
        seen_done = 1;
        check("done_cycle", cyc, exp_done);
        check("wb_data", wb_data, exp_wb);
      end
      cyc++;
    end
    check("done_seen", seen_done, 1);
    @(negedge clk);
    mem_ready = 1'b0;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("accesses", a, k);
    check("req_cycles", req_cycles, k * (w + 1));
    check("wr_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check("wr_addr", got_wr[i], exp_wr[i]);
  endtask

  initial begin
    proc_rst = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
    base_reg = '0; abort = 1'b0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    check("reset_wb", wb_data, 0);
    proc_rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_seq(1'b1, 16'h0040, 8'b1000_0101, 0, 3'd0);
    run_seq(1'b0, 16'h0200, 8'h03, 2, 3'd5);
    run_seq(1'b1, 16'h0300, 8'h00, 0, 3'd1);
    run_seq(1'b1, 16'hFFFF, 8'h03, 0, 3'd2);
    run_seq(1'b0, 16'h0010, 8'h05, 0, 3'd6);

    // Abort while a store access waits three cycles on memory.
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; base_addr = 16'h0100; reg_mask = 8'h03;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ab_req_c2", mem_req, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_req_c3", mem_req, 1);
    check("ab_addr_c3", mem_addr, 16'h0100);
    @(negedge clk);
    check("ab_req_c4", mem_req, 1);
    @(negedge clk);
    check("ab_req_c5", mem_req, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("ab_req_c6", mem_req, 0);
    check("ab_busy_c6", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ab_no_done", done, 0);
      check("ab_no_req", mem_req, 0);
    end

    // Abort in the first SCAN cycle.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0500; reg_mask = 8'h0F;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("scan_ab_busy", busy, 0);
    check("scan_ab_req", mem_req, 0);

    // Reset mid-operation while a request is outstanding.
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; base_addr = 16'h1234; reg_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_req_before", mem_req, 1);
    #1 proc_rst = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    proc_rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_after");

    for (int t = 0; t < 25; t++)
      run_seq(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 3), 3'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
